uc_multi_queue: RTL and testbench
=================================

# uc_multi_queue

Multi-port unit-clause queue for the BCP datapath. It takes up to NUM_PUSH signed literals per cycle from parallel process engines and stores them in FIFO order. Literals already queued are suppressed, and a push whose negation is already queued raises a sticky conflict. A single pop port feeds the unit-clause arbiter. It replaces the single-push unit-clause queue with a wider, deeper, self-checking buffer.

## Interface
- LIT_W, 10: signed literal width, sign included; literal 0 is invalid.
- DEPTH, 8: entry count; power of two, ≥ 2, and DEPTH ≥ NUM_PUSH.
- NUM_PUSH, 2: push lanes per cycle, 1..4.
- DEDUP, 1: 1 enables duplicate suppression and conflict detection; 0 queues every valid lane.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- flush  in  1  clears the queue and the conflict state.
- push_valid  in  NUM_PUSH  per-lane push request.
- push_lit  in  NUM_PUSH*LIT_W  lane i occupies bits [i*LIT_W +: LIT_W], signed.
- push_ready  out  1  all lanes may push this cycle.
- pop  in  1  dequeue request.
- pop_valid  out  1  registered; pop_lit was loaded by the previous cycle's pop.
- pop_lit  out  LIT_W  registered dequeued literal.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- count  out  $clog2(DEPTH)+1  occupancy.
- conflict  out  1  sticky conflict flag.
- conflict_lit  out  LIT_W  offending pushed literal.

## Operation
- **Storage:** circular buffer with head and tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a count register.
- **push_ready:** combinational, equal to (DEPTH − count ≥ NUM_PUSH) && !conflict. It uses the start-of-cycle count and gets no credit for a same-cycle pop.
- **Lane qualification:** lane i is a candidate iff push_valid[i] && push_ready && push_lit[i] != 0. When push_ready is 0, all lanes are ignored with no side effects.
- **Lane processing (DEDUP=1):** lanes are processed in ascending index order. Each candidate is compared against every resident entry (pre-update state, including an entry being popped this cycle) and against lower-index lanes already accepted this cycle.
  - Equal literal: the lane is dropped silently.
  - Negated literal (x == −y): conflict. conflict ← 1 and conflict_lit ← lowest such lane's literal. That lane and all higher lanes are dropped. Lower lanes already accepted stay enqueued.
  - Otherwise: the lane is accepted.
- **Enqueue:** accepted lanes are written at tail, tail+1, … in lane order, and tail advances by the number accepted (A).
- **Pop:** if pop && !empty, pop_lit ← entry[head], head ← head+1, pop_valid ← 1 (P = 1). Otherwise pop_valid ← 0 and pop_lit holds. A pop when empty is a no-op.
- **Count:** count_next = count + A − P.
- **Conflict:** sticky until flush or reset. While it is set, pushes are blocked but pops continue normally.
- **flush:** count, head and tail ← 0; conflict and pop_valid ← 0; conflict_lit ← 0. Pushes and pops in the flush cycle are ignored.
- **Reset (rst_n low at the edge):** same effect as flush, and entries ← 0. Reset overrides flush and any in-flight operation.
- **DEDUP=0:** no comparisons are made, and conflict and conflict_lit stay 0.

## Timing
- **Reset values:** push_ready = 1 (NUM_PUSH ≤ DEPTH), pop_valid = 0, pop_lit = 0, empty = 1, full = 0, count = 0, conflict = 0, conflict_lit = 0.
- **Push to pop:** a literal accepted at edge N can be popped in cycle N+1 and appears on pop_lit after edge N+2.
- **Pop latency:** 1 cycle, from the pop-sampled edge to pop_valid/pop_lit.
- **Flags:** empty, full and count reflect registered state and update the cycle after the causing edge.
- **Conflict latency:** conflict asserts the cycle after the offending push, and push_ready drops in that same cycle.
- **Simultaneous push and pop at full−k:** push_ready follows the rule above. A pop and pushes in the same cycle are both applied.

## Test plan
- **Reset values:** hold rst_n low for 2 cycles, then release. Check count = 0, empty = 1, push_ready = 1, pop_valid = 0.
- **Dual-lane FIFO order:** push lanes {3, −5}, then {7, 2}, then pop ×4. Expect pop_lit 3, −5, 7, 2 on consecutive cycles with pop_valid = 1 each, then empty = 1.
- **Duplicate suppression:** queue {4}, then push {4, 4}. Expect count to stay 1. Then push {6, 6}; expect count 2 and popping to return 4 then 6.
- **Conflict:** queue {9}, then push {1, −9}. Expect conflict = 1 and conflict_lit = −9 next cycle, count = 2, push_ready = 0. Pops still return 9 then 1. A flush clears conflict and restores push_ready = 1.
- **Wrap and full:** with DEPTH = 8, push 4 cycles of 2 distinct literals. Expect full = 1 and push_ready = 0. Pop 3 and push 2 more across the wrap boundary; pop all and check exact FIFO order. A pop on empty leaves pop_valid = 0 and count = 0.
- **Reset mid-operation:** with count = 5 and a pop asserted, drive rst_n = 0 for one edge. Expect count = 0 and pop_valid = 0 next cycle, with no stale data on later pops.

Source files
------------

// File: rtl/uc_multi_queue.sv
// Multi-port unit-clause queue: up to NUM_PUSH literals enqueued per cycle in lane order,
// optional duplicate suppression and sticky conflict detection, single registered pop port.
module uc_multi_queue #(
  parameter int LIT_W    = 10,
  parameter int DEPTH    = 8,
  parameter int NUM_PUSH = 2,
  parameter int DEDUP    = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic [NUM_PUSH-1:0]         push_valid,
  input  logic [NUM_PUSH*LIT_W-1:0]   push_lit,
  output logic                        push_ready,
  input  logic                        pop,
  output logic                        pop_valid,
  output logic [LIT_W-1:0]            pop_lit,
  output logic                        empty,
  output logic                        full,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        conflict,
  output logic [LIT_W-1:0]            conflict_lit
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - NUM_PUSH);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  logic [LIT_W-1:0] mem [DEPTH];
  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    cnt;
  logic             conflict_q;
  logic [LIT_W-1:0] conflict_lit_q;
  logic             pop_valid_q;
  logic [LIT_W-1:0] pop_lit_q;

  logic [DEPTH-1:0]    resident;
  logic [PW-1:0]       slot_rel;
  logic [LIT_W-1:0]    lane_lit [NUM_PUSH];
  logic [PW-1:0]       wr_idx   [NUM_PUSH];
  logic [NUM_PUSH-1:0] lane_acc;
  logic [CW-1:0]       n_acc;
  logic                conf_hit;
  logic [LIT_W-1:0]    conf_lit;
  logic                stop;
  logic                dup, opp;
  logic [LIT_W-1:0]    cur, neg;
  logic                do_pop;

  assign push_ready   = (cnt <= READY_MAX) && !conflict_q;
  assign empty        = (cnt == '0);
  assign full         = (cnt == FULL_CNT);
  assign count        = cnt;
  assign conflict     = conflict_q;
  assign conflict_lit = conflict_lit_q;
  assign pop_valid    = pop_valid_q;
  assign pop_lit      = pop_lit_q;
  assign do_pop       = pop && (cnt != '0);

  // A slot is resident when its distance from head (mod DEPTH) is below count.
  always_comb begin
    resident = '0;
    slot_rel = '0;
    for (int unsigned s = 0; s < DEPTH; s++) begin
      slot_rel    = PW'(s) - head;
      resident[s] = ({1'b0, slot_rel} < cnt);
    end
  end

  // Lanes resolve in ascending order; a conflicting lane stops every higher lane.
  always_comb begin
    lane_acc = '0;
    n_acc    = '0;
    conf_hit = 1'b0;
    conf_lit = '0;
    stop     = 1'b0;
    dup      = 1'b0;
    opp      = 1'b0;
    cur      = '0;
    neg      = '0;
    for (int unsigned i = 0; i < NUM_PUSH; i++) begin
      lane_lit[i] = push_lit[i*LIT_W +: LIT_W];
      wr_idx[i]   = '0;
    end
    for (int unsigned i = 0; i < NUM_PUSH; i++) begin
      cur       = lane_lit[i];
      neg       = '0 - cur;
      dup       = 1'b0;
      opp       = 1'b0;
      wr_idx[i] = tail + PW'(n_acc);
      if (push_valid[i] && push_ready && (cur != '0) && !stop) begin
        if (DEDUP != 0) begin
          for (int unsigned s = 0; s < DEPTH; s++) begin
            if (resident[s]) begin
              if (mem[s] == cur)      dup = 1'b1;
              else if (mem[s] == neg) opp = 1'b1;
            end
          end
          for (int unsigned j = 0; j < i; j++) begin
            if (lane_acc[j]) begin
              if (lane_lit[j] == cur)      dup = 1'b1;
              else if (lane_lit[j] == neg) opp = 1'b1;
            end
          end
        end
        if (dup) begin
          lane_acc[i] = 1'b0;
        end else if (opp) begin
          conf_hit = 1'b1;
          conf_lit = cur;
          stop     = 1'b1;
        end else begin
          lane_acc[i] = 1'b1;
          n_acc       = n_acc + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head           <= '0;
      tail           <= '0;
      cnt            <= '0;
      conflict_q     <= 1'b0;
      conflict_lit_q <= '0;
      pop_valid_q    <= 1'b0;
      pop_lit_q      <= '0;
      for (int unsigned s = 0; s < DEPTH; s++) mem[s] <= '0;
    end else if (flush) begin
      head           <= '0;
      tail           <= '0;
      cnt            <= '0;
      conflict_q     <= 1'b0;
      conflict_lit_q <= '0;
      pop_valid_q    <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_PUSH; i++) begin
        if (lane_acc[i]) mem[wr_idx[i]] <= lane_lit[i];
      end
      tail <= tail + PW'(n_acc);
      cnt  <= cnt + n_acc - CW'(do_pop);
      pop_valid_q <= do_pop;
      if (do_pop) begin
        pop_lit_q <= mem[head];
        head      <= head + PW'(1);
      end
      if (conf_hit) begin
        conflict_q     <= 1'b1;
        conflict_lit_q <= conf_lit;
      end
    end
  end

endmodule

// File: tb/tb_uc_multi_queue.sv
// Directed self-checking bench for uc_multi_queue at LIT_W=10, DEPTH=8, NUM_PUSH=2, DEDUP=1.
module tb_uc_multi_queue;

  localparam int LIT_W    = 10;
  localparam int DEPTH    = 8;
  localparam int NUM_PUSH = 2;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      flush;
  logic [NUM_PUSH-1:0]       push_valid;
  logic [NUM_PUSH*LIT_W-1:0] push_lit;
  logic                      push_ready;
  logic                      pop;
  logic                      pop_valid;
  logic [LIT_W-1:0]          pop_lit;
  logic                      empty;
  logic                      full;
  logic [$clog2(DEPTH):0]    count;
  logic                      conflict;
  logic [LIT_W-1:0]          conflict_lit;

  int checks = 0;
  int errors = 0;

  uc_multi_queue #(.LIT_W(LIT_W), .DEPTH(DEPTH), .NUM_PUSH(NUM_PUSH), .DEDUP(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .push_valid(push_valid), .push_lit(push_lit),
    .push_ready(push_ready), .pop(pop), .pop_valid(pop_valid), .pop_lit(pop_lit),
    .empty(empty), .full(full), .count(count), .conflict(conflict), .conflict_lit(conflict_lit)
  );

  always #5 clk = ~clk;

  function automatic logic [LIT_W-1:0] L(input int v);
    return v[LIT_W-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic [1:0] v, input int a, input int b);
    push_valid = v;
    push_lit   = {L(b), L(a)};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; pop = 1'b0; set_push(2'b00, 0, 0);
    step(); step();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b expected 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b expected 0", full); end
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL reset_push_ready: got %0b expected 1", push_ready); end
    checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL reset_pop_valid: got %0b expected 0", pop_valid); end
    checks++; if (pop_lit !== L(0)) begin errors++; $display("FAIL reset_pop_lit: got %0d expected 0", $signed(pop_lit)); end
    checks++; if (conflict !== 1'b0 || conflict_lit !== L(0)) begin errors++; $display("FAIL reset_conflict: got %0b/%0d expected 0/0", conflict, $signed(conflict_lit)); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fifo_order();
    int exp_lit [4] = '{3, -5, 7, 2};
    set_push(2'b11, 3, -5); step();
    set_push(2'b11, 7, 2);  step();
    set_push(2'b00, 0, 0);
    checks++; if (count !== 4'd4) begin errors++; $display("FAIL fifo_count: got %0d expected 4", count); end
    pop = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (pop_valid !== 1'b1 || pop_lit !== L(exp_lit[k])) begin errors++; $display("FAIL fifo_pop%0d: got valid=%0b lit=%0d expected valid=1 lit=%0d", k, pop_valid, $signed(pop_lit), exp_lit[k]); end
    end
    pop = 1'b0; step();
    checks++; if (empty !== 1'b1 || pop_valid !== 1'b0) begin errors++; $display("FAIL fifo_drained: got empty=%0b pop_valid=%0b expected 1/0", empty, pop_valid); end
  endtask

  task automatic test_dedup();
    set_push(2'b01, 4, 0); step();
    set_push(2'b11, 4, 4); step();
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL dedup_resident: got count %0d expected 1", count); end
    set_push(2'b11, 6, 6); step();
    set_push(2'b00, 0, 0);
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL dedup_lanes: got count %0d expected 2", count); end
    pop = 1'b1; step();
    checks++; if (pop_lit !== L(4)) begin errors++; $display("FAIL dedup_pop0: got %0d expected 4", $signed(pop_lit)); end
    step();
    checks++; if (pop_lit !== L(6)) begin errors++; $display("FAIL dedup_pop1: got %0d expected 6", $signed(pop_lit)); end
    pop = 1'b0; step();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL dedup_empty: got %0b expected 1", empty); end
  endtask

  task automatic test_conflict();
    set_push(2'b01, 9, 0);  step();
    set_push(2'b11, 1, -9); step();
    set_push(2'b00, 0, 0);
    checks++; if (conflict !== 1'b1 || conflict_lit !== L(-9)) begin errors++; $display("FAIL conflict_flag: got %0b/%0d expected 1/-9", conflict, $signed(conflict_lit)); end
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL conflict_count: got %0d expected 2", count); end
    checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL conflict_ready: got %0b expected 0", push_ready); end
    set_push(2'b01, 11, 0); step();
    set_push(2'b00, 0, 0);
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL conflict_blocked: got count %0d expected 2", count); end
    pop = 1'b1; step();
    checks++; if (pop_valid !== 1'b1 || pop_lit !== L(9)) begin errors++; $display("FAIL conflict_pop0: got %0b/%0d expected 1/9", pop_valid, $signed(pop_lit)); end
    step();
    checks++; if (pop_valid !== 1'b1 || pop_lit !== L(1)) begin errors++; $display("FAIL conflict_pop1: got %0b/%0d expected 1/1", pop_valid, $signed(pop_lit)); end
    pop = 1'b0; flush = 1'b1; step(); flush = 1'b0;
    checks++; if (conflict !== 1'b0 || conflict_lit !== L(0) || push_ready !== 1'b1) begin errors++; $display("FAIL conflict_flush: got conflict=%0b lit=%0d ready=%0b expected 0/0/1", conflict, $signed(conflict_lit), push_ready); end
    // lane 0 conflicts with a resident entry, so lane 1 must be dropped too
    set_push(2'b01, 12, 0);  step();
    set_push(2'b11, -12, 13); step();
    set_push(2'b00, 0, 0);
    checks++; if (count !== 4'd1 || conflict_lit !== L(-12)) begin errors++; $display("FAIL conflict_lane0: got count=%0d lit=%0d expected 1/-12", count, $signed(conflict_lit)); end
    flush = 1'b1; step(); flush = 1'b0;
    // conflict between two lanes of the same cycle keeps the lower lane
    set_push(2'b11, 5, -5); step();
    set_push(2'b00, 0, 0);
    checks++; if (count !== 4'd1 || conflict !== 1'b1 || conflict_lit !== L(-5)) begin errors++; $display("FAIL conflict_intra: got count=%0d conflict=%0b lit=%0d expected 1/1/-5", count, conflict, $signed(conflict_lit)); end
    flush = 1'b1; step(); flush = 1'b0;
    checks++; if (count !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
  endtask

  task automatic test_wrap_full();
    int exp_lit [7] = '{4, 5, 6, 7, 8, 9, 10};
    set_push(2'b11, 20, 21); step();
    set_push(2'b00, 0, 0); pop = 1'b1; step();
    checks++; if (pop_lit !== L(20)) begin errors++; $display("FAIL wrap_pre0: got %0d expected 20", $signed(pop_lit)); end
    step();
    checks++; if (pop_lit !== L(21)) begin errors++; $display("FAIL wrap_pre1: got %0d expected 21", $signed(pop_lit)); end
    pop = 1'b0;
    set_push(2'b11, 1, 2); step();
    set_push(2'b11, 3, 4); step();
    set_push(2'b11, 5, 6); step();
    checks++; if (count !== 4'd6 || push_ready !== 1'b1) begin errors++; $display("FAIL wrap_six: got count=%0d ready=%0b expected 6/1", count, push_ready); end
    set_push(2'b11, 7, 8); step();
    checks++; if (full !== 1'b1 || count !== 4'd8 || push_ready !== 1'b0) begin errors++; $display("FAIL wrap_full: got full=%0b count=%0d ready=%0b expected 1/8/0", full, count, push_ready); end
    set_push(2'b11, 50, 51); step();
    set_push(2'b00, 0, 0);
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL wrap_full_ignored: got count %0d expected 8", count); end
    pop = 1'b1; step();
    checks++; if (pop_lit !== L(1)) begin errors++; $display("FAIL wrap_pop1: got %0d expected 1", $signed(pop_lit)); end
    step();
    checks++; if (pop_lit !== L(2) || push_ready !== 1'b1) begin errors++; $display("FAIL wrap_pop2: got lit=%0d ready=%0b expected 2/1", $signed(pop_lit), push_ready); end
    set_push(2'b11, 9, 10); step();
    set_push(2'b00, 0, 0);
    checks++; if (pop_lit !== L(3) || count !== 4'd7 || push_ready !== 1'b0) begin errors++; $display("FAIL wrap_push_pop: got lit=%0d count=%0d ready=%0b expected 3/7/0", $signed(pop_lit), count, push_ready); end
    for (int k = 0; k < 7; k++) begin
      step();
      checks++; if (pop_valid !== 1'b1 || pop_lit !== L(exp_lit[k])) begin errors++; $display("FAIL wrap_drain%0d: got valid=%0b lit=%0d expected 1/%0d", k, pop_valid, $signed(pop_lit), exp_lit[k]); end
    end
    step();
    checks++; if (pop_valid !== 1'b0 || count !== 4'd0 || pop_lit !== L(10)) begin errors++; $display("FAIL wrap_pop_empty: got valid=%0b count=%0d lit=%0d expected 0/0/10", pop_valid, count, $signed(pop_lit)); end
    pop = 1'b0; step();
  endtask

  task automatic test_reset_mid();
    set_push(2'b11, 31, 32); step();
    set_push(2'b11, 33, 34); step();
    set_push(2'b11, 35, 0);  step();
    set_push(2'b00, 0, 0);
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL midrst_zero_lane: got count %0d expected 5", count); end
    pop = 1'b1; rst_n = 1'b0; step();
    checks++; if (count !== 4'd0 || pop_valid !== 1'b0 || pop_lit !== L(0) || empty !== 1'b1) begin errors++; $display("FAIL midrst_state: got count=%0d valid=%0b lit=%0d empty=%0b expected 0/0/0/1", count, pop_valid, $signed(pop_lit), empty); end
    rst_n = 1'b1; step();
    checks++; if (pop_valid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL midrst_pop_empty: got valid=%0b count=%0d expected 0/0", pop_valid, count); end
    pop = 1'b0;
    set_push(2'b01, 31, 0); step();
    set_push(2'b00, 0, 0);
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL midrst_repush: got count %0d expected 1", count); end
    pop = 1'b1; step();
    checks++; if (pop_valid !== 1'b1 || pop_lit !== L(31)) begin errors++; $display("FAIL midrst_pop: got valid=%0b lit=%0d expected 1/31", pop_valid, $signed(pop_lit)); end
    pop = 1'b0; step();
  endtask

  initial begin
    test_reset();
    test_fifo_order();
    test_dedup();
    test_conflict();
    test_wrap_full();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
